// File: rtl/priority_encoder32_5.sv
// priority_encoder32_5
//   Accepts a 32-bit multi-hot request vector and emits the index of every set
//   bit, lowest index first, one index per output handshake. The popcount of
//   the accepted vector is reported alongside. An all-zero vector produces no
//   indices, only a one-cycle zero_pulse.
//
// Ports
//   clk        : single clock, all state updates on the rising edge
//   reset_n    : synchronous active-low reset
//   in_valid   : in_vec is valid this cycle
//   in_ready   : block can accept a vector (IDLE and not in reset)
//   in_vec     : request vector, bit i requests index i
//   out_valid  : out_idx holds a valid index
//   out_ready  : consumer accepts out_idx
//   out_idx    : index of the lowest pending bit (0 when out_valid is low)
//   out_last   : current index is the final one of this vector
//   out_count  : popcount of the accepted vector, 0..32
//   zero_pulse : one-cycle flag that an all-zero vector was accepted
module priority_encoder32_5 (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_vec,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_idx,
  output logic        out_last,
  output logic [5:0]  out_count,
  output logic        zero_pulse
);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t      state_r;
  logic [31:0] pending_r;
  logic [5:0]  count_r;
  logic        zero_pulse_r;
  logic [4:0]  low_idx_s;
  logic        one_left_s;

  // Number of set bits in a 32-bit vector.
  function automatic logic [5:0] popcount32(input logic [31:0] v);
    logic [5:0] cnt;
    cnt = 6'd0;
    for (int i = 0; i < 32; i++) begin
      cnt = cnt + {5'd0, v[i]};
    end
    return cnt;
  endfunction

  // Index of the lowest set bit; scanning downward lets the lowest hit win.
  function automatic logic [4:0] lowest_set(input logic [31:0] v);
    logic [4:0] idx;
    idx = 5'd0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) begin
        idx = i[4:0];
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // Decode of the pending register: lowest index and "exactly one bit left".
  always_comb begin
    low_idx_s  = lowest_set(pending_r);
    // Clearing the lowest set bit leaves zero only if a single bit was set.
    one_left_s = (pending_r != 32'd0) &&
                 ((pending_r & (pending_r - 32'd1)) == 32'd0);
  end

  // Output decode from the registered state.
  always_comb begin
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_idx    = 5'd0;
    out_last   = 1'b0;
    case (state_r)
      IDLE: begin
        in_ready = reset_n;
      end
      SCAN: begin
        out_valid = 1'b1;
        out_idx   = low_idx_s;
        out_last  = one_left_s;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  assign out_count  = count_r;
  assign zero_pulse = zero_pulse_r;

  // State, pending bits, popcount and zero flag.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r      <= IDLE;
      pending_r    <= 32'd0;
      count_r      <= 6'd0;
      zero_pulse_r <= 1'b0;
    end else begin
      zero_pulse_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            count_r <= popcount32(in_vec);
            if (in_vec != 32'd0) begin
              pending_r <= in_vec;
              state_r   <= SCAN;
            end else begin
              zero_pulse_r <= 1'b1;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        SCAN: begin
          if (out_ready) begin
            // Dropping the lowest set bit is the same as clearing pending[out_idx].
            pending_r <= pending_r & (pending_r - 32'd1);
            if (one_left_s) begin
              state_r <= IDLE;
            end else begin
              state_r <= SCAN;
            end
          end else begin
            state_r <= SCAN;
          end
        end
        default: begin
          state_r   <= IDLE;
          pending_r <= 32'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_priority_encoder32_5.sv
module tb_priority_encoder32_5;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_vec;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_idx;
  logic        out_last;
  logic [5:0]  out_count;
  logic        zero_pulse;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: queue of indices still to be emitted, in emission order.
  int exp_q[$];
  int exp_count = 0;
  bit exp_zp    = 1'b0;

  priority_encoder32_5 dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vec    (in_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .out_count (out_count),
    .zero_pulse(zero_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model update for one rising edge, using the inputs held across that edge.
  task automatic model_edge();
    if (!reset_n) begin
      exp_q.delete();
      exp_count = 0;
      exp_zp    = 1'b0;
    end else begin
      exp_zp = 1'b0;
      if (exp_q.size() == 0) begin
        if (in_valid) begin
          exp_count = 0;
          for (int i = 0; i < 32; i++) begin
            if (in_vec[i]) begin
              exp_count++;
              exp_q.push_back(i);
            end
          end
          if (in_vec == 32'd0) exp_zp = 1'b1;
        end
      end else if (out_ready) begin
        void'(exp_q.pop_front());
      end
    end
  endtask

  // One clock: advance model at the edge, compare every output 1 ns later.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_eq("out_valid", {31'd0, out_valid}, (exp_q.size() > 0) ? 32'd1 : 32'd0);
    check_eq("out_idx",   {27'd0, out_idx},   (exp_q.size() > 0) ? exp_q[0] : 32'd0);
    check_eq("out_last",  {31'd0, out_last},  (exp_q.size() == 1) ? 32'd1 : 32'd0);
    check_eq("out_count", {26'd0, out_count}, exp_count);
    check_eq("zero_pulse",{31'd0, zero_pulse}, {31'd0, exp_zp});
    check_eq("in_ready",  {31'd0, in_ready},
             ((exp_q.size() == 0) && reset_n) ? 32'd1 : 32'd0);
  endtask

  // Present one vector, then drain it with out_ready low for 'stall' cycles first.
  task automatic run_vec(input logic [31:0] vec, input int stall);
    int guard;
    in_valid  = 1'b1;
    in_vec    = vec;
    out_ready = 1'b0;
    cycle();
    in_valid = 1'b0;
    in_vec   = 32'hDEAD_BEEF;
    guard    = 0;
    while (exp_q.size() > 0 && guard < 200) begin
      out_ready = (guard >= stall);
      cycle();
      guard++;
    end
    if (guard >= 200) check_eq("drain_timeout", 32'd1, 32'd0);
    out_ready = 1'b0;
    cycle();
  endtask

  initial begin
    logic [31:0] v;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_vec    = 32'd0;
    out_ready = 1'b0;
    cycle();
    cycle();
    reset_n = 1'b1;
    cycle();

    // Directed cases.
    run_vec(32'h0000_0001, 0);
    run_vec(32'h8000_0005, 0);
    run_vec(32'h0000_0300, 3);
    run_vec(32'h0000_0000, 0);
    run_vec(32'hFFFF_FFFF, 0);
    run_vec(32'h8000_0000, 2);

    // Reset in the middle of a scan: indices 6 and 7 must never appear.
    in_valid  = 1'b1;
    in_vec    = 32'h0000_00F0;
    out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    cycle();
    cycle();
    reset_n = 1'b0;
    cycle();
    reset_n = 1'b1;
    cycle();
    cycle();

    // Randomized traffic, including input noise during SCAN and random resets.
    for (int n = 0; n < 2000; n++) begin
      in_valid  = ($urandom_range(0, 1) == 1);
      out_ready = ($urandom_range(0, 3) != 0);
      reset_n   = ($urandom_range(0, 99) != 0);
      case ($urandom_range(0, 4))
        0: v = 32'd0;
        1: v = 32'd1 << $urandom_range(0, 31);
        2: v = $urandom() & $urandom() & $urandom();
        3: v = $urandom();
        default: v = 32'hFFFF_FFFF;
      endcase
      in_vec = v;
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/priority_encoder32_5.md
PRIORITY_ENCODER32_5 -- requirements
Module: priority_encoder32_5

Interface
REQ-001 SHALL have no parameters; widths fixed at 32-bit request vector, 5-bit index.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-003 SHALL have port reset_n, input, 1: reset, synchronous, active-low.
REQ-004 SHALL have port in_valid, input, 1: in_vec is valid this cycle.
REQ-005 SHALL have port in_ready, output, 1: block can accept a vector.
REQ-006 SHALL have port in_vec, input, 32: multi-hot request vector; bit i requests index i.
REQ-007 SHALL have port out_valid, output, 1: out_idx holds a valid index.
REQ-008 SHALL have port out_ready, input, 1: consumer accepts out_idx.
REQ-009 SHALL have port out_idx, output, 5: encoded index of the current lowest pending bit.
REQ-010 SHALL have port out_last, output, 1: current index is the final one for this vector.
REQ-011 SHALL have port out_count, output, 6: popcount of the accepted vector, range 0..32.
REQ-012 SHALL have port zero_pulse, output, 1: one-cycle flag that an all-zero vector was accepted.

Function
REQ-013 SHALL implement two states, IDLE and SCAN, plus a 32-bit pending register.
REQ-014 SHALL drive in_ready = 1 only in IDLE with reset_n high, and in_ready = 0 in SCAN.
REQ-015 Accept condition: in_valid && in_ready, registered on that edge.
REQ-016 On accept of a non-zero in_vec, SHALL load pending = in_vec, load out_count = popcount(in_vec), and enter SCAN.
REQ-017 On accept of in_vec = 0, SHALL stay in IDLE, set out_count = 0, and assert zero_pulse for exactly the next cycle.
REQ-018 SHALL produce no out_valid for a zero vector.
REQ-019 In SCAN, SHALL assert out_valid = 1.
REQ-020 In SCAN, out_idx SHALL equal the lowest set bit index of pending; lowest index goes first.
REQ-021 out_last SHALL = 1 when pending has exactly one bit set; out_last SHALL = 0 whenever out_valid = 0.
REQ-022 Output handshake out_valid && out_ready SHALL clear pending[out_idx] on that edge.
REQ-023 If a handshake occurs with out_last = 1, SHALL return to IDLE on that edge.
REQ-024 Latency: a vector accepted at edge N SHALL give its first out_valid in the cycle after edge N.
REQ-025 With out_ready held high, SHALL issue one index per cycle.
REQ-026 in_ready SHALL rise in the cycle after the last handshake; SCAN and accept of the next vector never overlap.
REQ-027 Backpressure: while out_valid && !out_ready, out_idx and out_last SHALL hold stable and out_valid SHALL not drop.
REQ-028 in_vec and in_valid SHALL be ignored in SCAN.
REQ-029 out_count SHALL hold from accept until the next accept, including across the return to IDLE.
REQ-030 out_idx SHALL be 0 when out_valid = 0.
REQ-031 SHALL decode all 32 bit positions, including bit 31 (index 5'd31) and bit 0 (index 5'd0).

Reset
REQ-032 While reset_n = 0 at an edge, SHALL force IDLE, pending = 0, out_count = 0, and zero_pulse = 0.
REQ-033 After that edge, out_valid, out_last, and out_idx SHALL be 0.
REQ-034 in_ready SHALL = 0 while reset_n = 0 and = 1 in the first cycle after release.
REQ-035 Reset during SCAN SHALL discard the remaining pending bits; no further indices of that vector SHALL be emitted.

Verification
REQ-036 Single bit: reset, in_vec = 32'h0000_0001 accepted, out_ready = 1 -> one beat with out_idx = 0, out_last = 1, out_count = 1; in_ready = 1 the following cycle.
REQ-037 Sparse vector: in_vec = 32'h8000_0005, out_ready = 1 -> out_idx 0, 2, 31 on consecutive cycles; out_last only on 31; out_count = 3.
REQ-038 Backpressure: in_vec = 32'h0000_0300, out_ready low for 3 cycles then high -> out_idx = 8 stable for 4 cycles, then out_idx = 9 with out_last = 1.
REQ-039 Zero vector: in_vec = 0 accepted -> zero_pulse high for exactly 1 cycle, out_valid stays 0, in_ready stays 1, out_count = 0.
REQ-040 Full vector: in_vec = 32'hFFFF_FFFF, out_ready = 1 -> 32 beats with out_idx 0..31 in order, out_count = 32, out_last on beat 32 only.
REQ-041 Reset mid-scan: in_vec = 32'h0000_00F0, reset_n low after the second beat -> out_valid = 0 after the reset edge; in_ready = 1 after release; idx 6 and 7 never appear.
